// File: rtl/inst_rom_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encodings, bus types and control constants
// used by the instruction-memory responder.
package inst_rom_ctrl_pkg;

    typedef enum logic [1:0] {
        IfIdle = 2'd0,
        IfRdLo = 2'd1,
        IfRdHi = 2'd2,
        IfFill = 2'd3
    } if_state_t;

    typedef logic [31:0] inst_bus_t;
    typedef logic [15:0] flash_data_bus_t;

    localparam logic      ChipEnable  = 1'b1;
    localparam logic      ChipDisable = 1'b0;
    // This block's reset is active-low.
    localparam logic      RstEnable   = 1'b0;
    localparam inst_bus_t Nop         = 32'h0000_0000;

endpackage

// File: rtl/inst_rom_ctrl.sv
// Fetch-stage instruction responder: serves 32-bit instructions from a 16-bit
// asynchronous flash as two wait-stated halfword reads, with a one-entry buffer.
module inst_rom_ctrl
    import inst_rom_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int FLASH_AW    = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce_i,
    input  logic [31:0]         pc_i,
    output inst_bus_t           inst_o,
    output logic                stallreq_o,
    output logic [FLASH_AW-1:0] flash_addr_o,
    output logic                flash_ce_n_o,
    output logic                flash_oe_n_o,
    input  flash_data_bus_t     flash_data_i
);

    if_state_t        state, state_nxt;
    logic [3:0]       cnt;
    logic [29:0]      req_addr;
    flash_data_bus_t  lo, hi;

    logic             buf_valid;
    logic [29:0]      buf_tag;
    inst_bus_t        buf_data;

    logic             hit, miss, abort, phase_done, in_reset;
    logic             unused_pc_bits;

    // The word address is all that matters; the byte offset is ignored.
    assign unused_pc_bits = ^pc_i[1:0];

    assign in_reset   = (rst == RstEnable);
    assign hit        = (ce_i == ChipEnable) && buf_valid && (buf_tag == pc_i[31:2]);
    assign miss       = (ce_i == ChipEnable) && !hit;
    assign abort      = (ce_i == ChipDisable) || (pc_i[31:2] != req_addr);
    assign phase_done = (cnt == 4'(WAIT_CYCLES));

    assign stallreq_o = !in_reset && miss;
    assign inst_o     = (!in_reset && hit) ? buf_data : Nop;

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IfIdle: if (miss) state_nxt = IfRdLo;
            IfRdLo: begin
                if (abort)           state_nxt = IfIdle;
                else if (phase_done) state_nxt = IfRdHi;
            end
            IfRdHi: begin
                if (abort)           state_nxt = IfIdle;
                else if (phase_done) state_nxt = IfFill;
            end
            IfFill: state_nxt = IfIdle;
            default: state_nxt = IfIdle;
        endcase
    end

    // NOTE: all state here uses <= so every register samples pre-edge values consistently.
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state        <= IfIdle;
            cnt          <= 4'd0;
            req_addr     <= '0;
            lo           <= '0;
            hi           <= '0;
            buf_valid    <= 1'b0;
            buf_tag      <= '0;
            flash_addr_o <= '0;
            flash_ce_n_o <= 1'b1;
            flash_oe_n_o <= 1'b1;
        end else begin
            state        <= state_nxt;
            // Strobes are registered from the next state so they align with the address.
            flash_ce_n_o <= !(state_nxt == IfRdLo || state_nxt == IfRdHi);
            flash_oe_n_o <= !(state_nxt == IfRdLo || state_nxt == IfRdHi);

            case (state)
                IfIdle: begin
                    if (state_nxt == IfRdLo) begin
                        req_addr     <= pc_i[31:2];
                        cnt          <= 4'd0;
                        flash_addr_o <= {pc_i[FLASH_AW:2], 1'b0};
                    end
                end
                IfRdLo: begin
                    if (state_nxt == IfRdHi) begin
                        lo              <= flash_data_i;
                        cnt             <= 4'd0;
                        flash_addr_o[0] <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                IfRdHi: begin
                    if (state_nxt == IfFill) begin
                        hi  <= flash_data_i;
                        cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                IfFill: begin
                    buf_tag   <= req_addr;
                    buf_valid <= 1'b1;
                end
                default: ;
            endcase

            // A dropped fetch enable means the PC register restarted; forget the buffer.
            if (ce_i == ChipDisable) buf_valid <= 1'b0;
        end
    end

    // NOTE: buffer data has no reset; it is never observed unless buf_valid is set.
    always_ff @(posedge clk) begin
        if (!in_reset && state == IfFill) buf_data <= {hi, lo};
    end

endmodule

// File: doc/inst_rom_ctrl.md
# inst_rom_ctrl

Instruction-memory responder for the fetch stage. Accepts the `pc`/`ce` fetch request issued by the PC register and returns a 32-bit instruction. The instruction is read from an external 16-bit asynchronous flash/SRAM as two halfword reads with programmable wait states. While a fetch is outstanding it raises `stallreq_o` to the pipeline controller, which freezes the PC. A one-entry last-fetch buffer returns re-requested addresses without a new external access.

## Interface
Parameters:
- `WAIT_CYCLES`, 3, extra wait cycles per halfword access; legal range 0..15.
- `FLASH_AW`, 22, external halfword address width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-low (`rst`==0 resets on next rising edge).
- `ce_i`  in  1  fetch enable from the PC register.
- `pc_i`  in  32  byte address of the requested instruction; bits [1:0] ignored.
- `inst_o`  out  32  instruction; 0x00000000 (NOP) when not valid.
- `stallreq_o`  out  1  stall request to the pipeline controller.
- `flash_addr_o`  out  FLASH_AW  halfword address.
- `flash_ce_n_o`  out  1  external chip enable, active-low.
- `flash_oe_n_o`  out  1  external output enable, active-low.
- `flash_data_i`  in  16  external read data.

## Operation
- Buffer: `buf_valid`, `buf_tag[31:2]`, `buf_data[31:0]`.
- Hit when `ce_i`=1, `buf_valid`=1 and `buf_tag`==`pc_i[31:2]`. A hit gives `inst_o`=`buf_data` and `stallreq_o`=0, both combinational.
- Miss when `ce_i`=1 and not hit. A miss gives `stallreq_o`=1 (combinational, same cycle) and `inst_o`=0.
- When `ce_i`=0: `stallreq_o`=0, `inst_o`=0.
- FSM states: IDLE, RD_LO, RD_HI, FILL.
  - IDLE to RD_LO on a miss. At this edge, capture `req_addr`=`pc_i[31:2]` and clear the wait counter.
  - RD_LO: drive `flash_addr_o`={`req_addr`[FLASH_AW-2:0],0}, `ce_n`=0, `oe_n`=0. The counter increments each cycle. When the counter equals WAIT_CYCLES, latch `flash_data_i` into `lo` and move to RD_HI with the counter cleared.
  - RD_HI: same as RD_LO, except the address LSB is 1 and the data latches into `hi`. When the counter equals WAIT_CYCLES, move to FILL.
  - FILL: write `buf_data`={`hi`,`lo`}, `buf_tag`=`req_addr`, `buf_valid`=1, then return to IDLE. `stallreq_o` stays 1 during FILL; the hit appears the cycle after FILL.
- Abort: in RD_LO or RD_HI, if `ce_i`=0 or `pc_i[31:2]`≠`req_addr`, go to IDLE at the next edge. Partial data is discarded and `buf_valid` is unchanged. A new miss restarts from IDLE.
- `ce_i` falling clears `buf_valid` at that edge, so the buffer does not survive a PC-register reset.
- Outside RD_LO/RD_HI: `flash_ce_n_o`=1, `flash_oe_n_o`=1, `flash_addr_o` holds its last value.

## Timing
- Reset (`rst`=0 at an edge) sets:
  - state IDLE, counter 0, `buf_valid`=0, `lo`/`hi`=0, `flash_addr_o`=0;
  - `flash_ce_n_o`=1, `flash_oe_n_o`=1;
  - `inst_o`=0, `stallreq_o`=0 (forced 0 while `rst`=0).
- Reset mid-fetch aborts immediately; no partial data reaches the buffer.
- Miss latency: 1 (IDLE) + 2×(WAIT_CYCLES+1) + 1 (FILL) cycles of `stallreq_o`=1. Valid `inst_o` appears on the next cycle. With WAIT_CYCLES=3 this is 10 stall cycles.
- WAIT_CYCLES=0: each halfword takes 1 cycle, giving a 4-cycle stall.
- `flash_addr_o`/`ce_n`/`oe_n` are registered. Data is sampled at the edge that ends the phase, so it must be valid WAIT_CYCLES+1 cycles after the address changes.
- Counter width is 4 bits. It never wraps because it clears on every phase change.

## Structure
- Add to shared `defines.v`:
  - FSM state encodings: `IfIdle`, `IfRdLo`, `IfRdHi`, `IfFill`;
  - `FlashAddrBus`, `FlashDataBus`;
  - NOP constant 32'h0.
- Reuse the existing `ChipEnable`/`ChipDisable`, `RstEnable` (redefined 1'b0 for this block's polarity) and `InstBus`.
- No sub-module; single flat module (FSM, counter, buffer).

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `ce_i`=1 → `stallreq_o`=0, `inst_o`=0, `flash_ce_n_o`=1, `flash_oe_n_o`=1. Release → `stallreq_o`=1 in the same cycle.
- Cold fetch: WAIT_CYCLES=3, `pc_i`=0, flash[0]=0x1234, flash[1]=0xABCD → `stallreq_o`=1 for exactly 10 cycles, then `inst_o`=0xABCD1234 with `stallreq_o`=0.
- Hit: hold `pc_i`=0 after fill → `inst_o`=0xABCD1234 every cycle, with no `flash_ce_n_o` assertion.
- Sequential: `pc_i`=4 next, flash[2]=0x0001, flash[3]=0x3C08 → `flash_addr_o`=2 then 3; `inst_o`=0x3C080001.
- Abort: change `pc_i` 0x8→0x20 during RD_HI → IDLE next edge, then a fresh fetch of halfwords 0x10/0x11. The buffer never holds tag 0x2 with partial data.
- `ce_i` drop: deassert `ce_i` mid-RD_LO → `stallreq_o`=0, `inst_o`=0, chip deselected at next edge. Re-asserting `ce_i` with the old `pc_i` → full miss (`buf_valid` cleared).
